axil_sram_scheduler: RTL and testbench

Controller that sits behind the AXI-Lite 4 slave-side mux and shares one single-port synchronous SRAM between the AXI-Lite read and write channels. It arbitrates read against write round-robin, and issues exactly one SRAM access per accepted transaction. It also returns read data and write responses with deterministic latency. Only one transaction is in flight at a time.

---
 rtl/axil_pkg.sv | 22 ++
 rtl/rw_rr_arbiter.sv | 33 +++
 rtl/axil_sram_scheduler.sv | 177 +++++++++++++++++
 tb/tb_axil_sram_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite SRAM scheduler: response codes,
// FSM state encoding and transaction type tags.
package axil_pkg;

    localparam logic [31:0] RESP_OKAY   = 32'h0;
    localparam logic [31:0] RESP_SLVERR = 32'h2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_MEM,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_MEM,
        ST_WR_RESP
    } state_t;

    typedef enum logic {
        TYPE_READ  = 1'b0,
        TYPE_WRITE = 1'b1
    } xfer_type_t;

endpackage

// File: rtl/rw_rr_arbiter.sv
// Round-robin read/write arbiter; remembers the type of the last grant so
// that a tie always goes to the opposite type.
module rw_rr_arbiter
    import axil_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       enable,
    output xfer_type_t grant_type
);

    xfer_type_t r_last_type;

    always_comb begin
        grant_type = TYPE_READ;
        if (rd_req && wr_req) begin
            grant_type = (r_last_type == TYPE_WRITE) ? TYPE_READ : TYPE_WRITE;
        end else if (wr_req) begin
            grant_type = TYPE_WRITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_type <= TYPE_WRITE;
        end else if (enable && (rd_req || wr_req)) begin
            r_last_type <= grant_type;
        end
    end

endmodule

// File: rtl/axil_sram_scheduler.sv
// Shares one single-port synchronous SRAM between the AXI-Lite read and write
// channels, one transaction in flight, fixed response latency.
module axil_sram_scheduler
    import axil_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            readAddr_addr,
    input  logic                         readAddr_valid,
    output logic                         readAddr_ready,
    output logic [DATA_W-1:0]            readData_data,
    output logic                         readData_valid,
    input  logic                         readData_ready,
    input  logic [ADDR_W-1:0]            writeAddr_addr,
    input  logic                         writeAddr_valid,
    output logic                         writeAddr_ready,
    input  logic [DATA_W-1:0]            writeData_data,
    input  logic                         writeData_valid,
    output logic                         writeData_ready,
    output logic [31:0]                  writeResp_msg,
    output logic                         writeResp_valid,
    input  logic                         writeResp_ready,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         busy
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(MEM_LATENCY - 1);
    // Byte-address limit; two extra bits so the limit cannot wrap.
    localparam logic [ADDR_W+1:0] ADDR_LIMIT = (ADDR_W + 2)'(MEM_DEPTH) << 2;

    state_t                r_state;
    state_t                w_next_state;
    logic [MEM_AW-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic [CNT_W-1:0]      r_lat_cnt;

    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_idle;
    xfer_type_t            w_grant_type;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic                  w_sel_oor;
    logic                  w_rd_hs;
    logic                  w_wr_hs;
    logic                  w_lat_last;

    assign w_rd_req   = readAddr_valid;
    assign w_wr_req   = writeAddr_valid && writeData_valid;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_sel_addr = (w_grant_type == TYPE_READ) ? readAddr_addr : writeAddr_addr;
    assign w_sel_oor  = ({2'b00, w_sel_addr} >= ADDR_LIMIT);
    assign w_lat_last = (r_lat_cnt == LAT_LAST);
    assign w_rd_hs    = readAddr_ready;
    assign w_wr_hs    = writeAddr_ready;

    rw_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (w_rd_req),
        .wr_req     (w_wr_req),
        .enable     (w_idle),
        .grant_type (w_grant_type)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        readAddr_ready  = 1'b0;
        writeAddr_ready = 1'b0;
        writeData_ready = 1'b0;
        readData_valid  = 1'b0;
        writeResp_valid = 1'b0;
        writeResp_msg   = RESP_OKAY;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        busy            = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                // Grant handshake is combinational; rst gating keeps every output low during reset.
                if (!rst && w_rd_req && w_grant_type == TYPE_READ) begin
                    readAddr_ready = 1'b1;
                    w_next_state   = ST_RD_MEM;
                end else if (!rst && w_wr_req && w_grant_type == TYPE_WRITE) begin
                    writeAddr_ready = 1'b1;
                    writeData_ready = 1'b1;
                    w_next_state    = ST_WR_MEM;
                end
            end
            ST_RD_MEM: begin
                mem_en       = !r_err;
                w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_lat_last) begin
                    w_next_state = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                readData_valid = 1'b1;
                if (readData_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WR_MEM: begin
                mem_en       = !r_err;
                mem_we       = 1'b1;
                w_next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                writeResp_valid = 1'b1;
                writeResp_msg   = r_err ? RESP_SLVERR : RESP_OKAY;
                if (writeResp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_cnt <= '0;
        end else if (r_state == ST_RD_WAIT) begin
            r_lat_cnt <= w_lat_last ? '0 : r_lat_cnt + 1'b1;
        end else begin
            r_lat_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_rd_hs || w_wr_hs) begin
                r_mem_addr <= w_sel_addr[MEM_AW+1:2];
                r_err      <= w_sel_oor;
            end
            if (w_wr_hs) begin
                r_wdata <= writeData_data;
            end
            if (r_state == ST_RD_WAIT && w_lat_last) begin
                r_rdata <= r_err ? '0 : mem_rdata;
            end
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_wdata;
    assign readData_data = r_rdata;

endmodule

// File: tb/tb_axil_sram_scheduler.sv
// Directed bench for axil_sram_scheduler with MEM_LATENCY = 1; inputs change
// and outputs are sampled around the falling clock edge.
module tb_axil_sram_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] readAddr_addr;
    logic        readAddr_valid;
    logic        readAddr_ready;
    logic [31:0] readData_data;
    logic        readData_valid;
    logic        readData_ready;
    logic [31:0] writeAddr_addr;
    logic        writeAddr_valid;
    logic        writeAddr_ready;
    logic [31:0] writeData_data;
    logic        writeData_valid;
    logic        writeData_ready;
    logic [31:0] writeResp_msg;
    logic        writeResp_valid;
    logic        writeResp_ready;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks;
    int n_fail;

    axil_sram_scheduler #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_DEPTH   (1024),
        .MEM_LATENCY (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .readAddr_addr   (readAddr_addr),
        .readAddr_valid  (readAddr_valid),
        .readAddr_ready  (readAddr_ready),
        .readData_data   (readData_data),
        .readData_valid  (readData_valid),
        .readData_ready  (readData_ready),
        .writeAddr_addr  (writeAddr_addr),
        .writeAddr_valid (writeAddr_valid),
        .writeAddr_ready (writeAddr_ready),
        .writeData_data  (writeData_data),
        .writeData_valid (writeData_valid),
        .writeData_ready (writeData_ready),
        .writeResp_msg   (writeResp_msg),
        .writeResp_valid (writeResp_valid),
        .writeResp_ready (writeResp_ready),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        int   n_grants;
        logic overlap;
        logic seen_valid;

        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        readAddr_addr   = '0;
        readAddr_valid  = 1'b0;
        readData_ready  = 1'b1;
        writeAddr_addr  = '0;
        writeAddr_valid = 1'b0;
        writeData_data  = '0;
        writeData_valid = 1'b0;
        writeResp_ready = 1'b1;
        mem_rdata       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ctrl", {readAddr_ready, writeAddr_ready, writeData_ready, readData_valid,
                              writeResp_valid, mem_en, mem_we, busy}, 32'h0);
        check_eq("rst_mem_addr", {22'd0, mem_addr}, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_rdata", readData_data, 32'h0);
        check_eq("rst_msg", writeResp_msg, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Read 0x10: mem_en/addr 4 at T+1, data sampled in T+2, valid at T+3
        @(negedge clk);
        readAddr_addr  = 32'h10;
        readAddr_valid = 1'b1;
        #1;
        check_eq("rd_grant", {readAddr_ready, writeAddr_ready, writeData_ready}, 32'b100);
        @(negedge clk);
        readAddr_valid = 1'b0;
        #1;
        check_eq("rd_t1_en_we", {mem_en, mem_we, busy}, 32'b101);
        check_eq("rd_t1_addr", {22'd0, mem_addr}, 32'd4);
        @(negedge clk);
        mem_rdata = 32'hA5A5_A5A5;
        #1;
        check_eq("rd_t2_valid", {mem_en, readData_valid}, 32'b00);
        @(negedge clk);
        mem_rdata = 32'h1111_1111;
        #1;
        check_eq("rd_t3_valid", {31'd0, readData_valid}, 32'd1);
        check_eq("rd_t3_data", readData_data, 32'hA5A5_A5A5);
        @(negedge clk);
        #1;
        check_eq("rd_done", {readData_valid, busy}, 32'b00);

        // Write 0x20 <- 0x12345678
        @(negedge clk);
        writeAddr_addr  = 32'h20;
        writeData_data  = 32'h1234_5678;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        #1;
        check_eq("wr_grant", {readAddr_ready, writeAddr_ready, writeData_ready}, 32'b011);
        @(negedge clk);
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        #1;
        check_eq("wr_t1_en_we", {mem_en, mem_we}, 32'b11);
        check_eq("wr_t1_addr", {22'd0, mem_addr}, 32'd8);
        check_eq("wr_t1_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        #1;
        check_eq("wr_t2_valid", {mem_en, writeResp_valid}, 32'b01);
        check_eq("wr_t2_msg", writeResp_msg, 32'h0);
        @(negedge clk);
        #1;
        check_eq("wr_done", {writeResp_valid, busy}, 32'b00);

        // Out-of-range write at word address MEM_DEPTH
        @(negedge clk);
        writeAddr_addr  = 32'h1000;
        writeData_data  = 32'hCAFE_0001;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        @(negedge clk);
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        #1;
        check_eq("oorw_t1_en", {mem_en, busy}, 32'b01);
        @(negedge clk);
        #1;
        check_eq("oorw_t2_valid", {31'd0, writeResp_valid}, 32'd1);
        check_eq("oorw_t2_msg", writeResp_msg, 32'h2);

        // Out-of-range read returns zero even with live mem_rdata
        @(negedge clk);
        readAddr_addr  = 32'h1003;
        readAddr_valid = 1'b1;
        @(negedge clk);
        readAddr_valid = 1'b0;
        #1;
        check_eq("oorr_t1_en", {mem_en, busy}, 32'b01);
        @(negedge clk);
        mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        #1;
        check_eq("oorr_t3_valid", {31'd0, readData_valid}, 32'd1);
        check_eq("oorr_t3_data", readData_data, 32'h0);

        // Read back-pressure with a pending write that must not be granted
        @(negedge clk);
        readData_ready = 1'b0;
        readAddr_addr  = 32'h14;
        readAddr_valid = 1'b1;
        @(negedge clk);
        readAddr_valid = 1'b0;
        #1;
        check_eq("bp_t1_addr", {22'd0, mem_addr}, 32'd5);
        @(negedge clk);
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rdata       = 32'h0;
        writeAddr_addr  = 32'h40;
        writeData_data  = 32'h0BAD_F00D;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_hold_valid", {31'd0, readData_valid}, 32'd1);
            check_eq("bp_hold_data", readData_data, 32'hDEAD_BEEF);
            check_eq("bp_hold_nogrant", {readAddr_ready, writeAddr_ready, writeData_ready}, 32'b000);
            @(negedge clk);
        end
        readData_ready = 1'b1;
        #1;
        check_eq("bp_hs_cycle", {readData_valid, writeAddr_ready}, 32'b10);
        @(negedge clk);
        #1;
        check_eq("bp_next_grant", {readData_valid, writeAddr_ready, writeData_ready}, 32'b011);
        @(negedge clk);
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        #1;
        check_eq("bp_wr_addr", {22'd0, mem_addr}, 32'd16);
        check_eq("bp_wr_wdata", mem_wdata, 32'h0BAD_F00D);
        @(negedge clk);
        #1;
        check_eq("bp_wr_resp", {31'd0, writeResp_valid}, 32'd1);

        // Reset asserted in RD_WAIT
        @(negedge clk);
        readAddr_addr  = 32'h18;
        readAddr_valid = 1'b1;
        @(negedge clk);
        readAddr_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rw_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rw_rst_ctrl", {readAddr_ready, writeAddr_ready, readData_valid,
                                 writeResp_valid, mem_en, mem_we, busy}, 32'h0);
        check_eq("rw_rst_data", readData_data, 32'h0);
        check_eq("rw_rst_addr", {22'd0, mem_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (readData_valid || busy) seen_valid = 1'b1;
        end
        check_eq("rw_no_resp_after_rst", {31'd0, seen_valid}, 32'd0);

        // Reset asserted in RD_MEM drops mem_en without a clock edge
        @(negedge clk);
        readAddr_addr  = 32'h1C;
        readAddr_valid = 1'b1;
        @(negedge clk);
        readAddr_valid = 1'b0;
        #1;
        check_eq("rm_pre_en", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rm_rst_en", {mem_en, busy}, 32'b00);
        @(negedge clk);
        rst = 1'b0;

        // Continuous read and write requests alternate R, W, R, W ...
        @(negedge clk);
        readAddr_addr   = 32'h10;
        readAddr_valid  = 1'b1;
        writeAddr_addr  = 32'h24;
        writeData_data  = 32'h7777_0000;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        n_grants = 0;
        overlap  = 1'b0;
        for (int cyc = 0; cyc < 100 && n_grants < 8; cyc++) begin
            #1;
            if (readAddr_ready && (writeAddr_ready || writeData_ready)) overlap = 1'b1;
            if (readAddr_ready || writeAddr_ready || writeData_ready) begin
                check_eq($sformatf("alt_grant%0d", n_grants),
                         {readAddr_ready, writeAddr_ready, writeData_ready},
                         (n_grants % 2 == 0) ? 32'b100 : 32'b011);
                n_grants++;
            end
            @(negedge clk);
        end
        readAddr_valid  = 1'b0;
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        check_eq("alt_count", n_grants, 32'd8);
        check_eq("alt_overlap", {31'd0, overlap}, 32'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
